// File: rtl/commit_pkg.sv
// Shared types for the commit tracker: FSM states, trap opcode default, commit record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package commit_pkg;

  typedef enum logic {
    ST_RUN,
    ST_TRAPPED
  } state_e;

  localparam logic [6:0] TRAP_OPCODE_DEF = 7'h6b;

  // Record fields are sized for the widest supported XLEN; narrower builds
  // use the low bits of pc/wdata.
  localparam int CM_XLEN = 64;

  typedef struct packed {
    logic [CM_XLEN-1:0] pc;
    logic [31:0]        inst;
    logic               wen;
    logic [4:0]         wdest;
    logic [CM_XLEN-1:0] wdata;
    logic               skip;
  } commit_rec_t;

endpackage

// File: rtl/commit_mask_pcnt.sv
// Masks retirements younger than the oldest trap hit; popcount and highest surviving channel.
// Latency: purely combinational.
// Backpressure: none.
// Ports: valid/hit per channel in; unmasked vector, its popcount and the highest
// unmasked channel index out (index is 0 when nothing survives).
module commit_mask_pcnt #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1),
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [N-1:0]  hit,
  output logic [N-1:0]  unmasked,
  output logic [CW-1:0] count,
  output logic [IW-1:0] hi_idx
);

  logic blocked;

  always_comb begin
    unmasked = '0;
    count    = '0;
    hi_idx   = '0;
    blocked  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && !blocked) begin
        unmasked[i] = 1'b1;
        count       = count + CW'(1);
        hi_idx      = IW'(i);
      end
      // Everything younger than the first trap hit is dropped.
      if (valid[i] && hit[i]) begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/commit_tracker.sv
// Registers up to NCOMMIT retirements per cycle, masks after a trap, keeps counters and a sticky trap.
// Latency: 1 cycle from in_* to cmt_*, trap_* and counters.
// Backpressure: none; inputs are sampled every RUN cycle and ignored once TRAPPED.
// Ports: clock/reset (sync, active-high); in_* per-channel retire info, channel i at
// [i*W +: W], channel 0 oldest; in_a0 supplies the trap code; cmt_* registered commits;
// trap/trap_code/trap_pc sticky trap info; cycle_cnt/instr_cnt 64-bit wrapping counters.
// Build option: COMMIT_WATCHDOG_EN adds an idle watchdog that traps with WDT_CODE.
module commit_tracker
  import commit_pkg::*;
#(
  parameter int          NCOMMIT     = 2,
  parameter int          XLEN        = 64,
  parameter logic [6:0]  TRAP_OPCODE = TRAP_OPCODE_DEF,
  parameter int unsigned WDT_CYCLES  = 4096,
  parameter logic [7:0]  WDT_CODE    = 8'hff
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCOMMIT-1:0]      in_valid,
  input  logic [NCOMMIT*XLEN-1:0] in_pc,
  input  logic [NCOMMIT*32-1:0]   in_inst,
  input  logic [NCOMMIT-1:0]      in_wen,
  input  logic [NCOMMIT*5-1:0]    in_wdest,
  input  logic [NCOMMIT*XLEN-1:0] in_wdata,
  input  logic [NCOMMIT-1:0]      in_skip,
  input  logic [XLEN-1:0]         in_a0,
  output logic [NCOMMIT-1:0]      cmt_valid,
  output logic [NCOMMIT*XLEN-1:0] cmt_pc,
  output logic [NCOMMIT*32-1:0]   cmt_inst,
  output logic [NCOMMIT-1:0]      cmt_wen,
  output logic [NCOMMIT*8-1:0]    cmt_wdest,
  output logic [NCOMMIT*XLEN-1:0] cmt_wdata,
  output logic [NCOMMIT-1:0]      cmt_skip,
  output logic                    trap,
  output logic [7:0]              trap_code,
  output logic [XLEN-1:0]         trap_pc,
  output logic [63:0]             cycle_cnt,
  output logic [63:0]             instr_cnt
);

  localparam int CW = $clog2(NCOMMIT + 1);
  localparam int IW = (NCOMMIT > 1) ? $clog2(NCOMMIT) : 1;

  state_e              state_q, state_d;
  logic [NCOMMIT-1:0]  hit;
  logic [NCOMMIT-1:0]  unmasked;
  logic [CW-1:0]       pcnt;
  logic [IW-1:0]       hi_idx;
  logic [XLEN-1:0]     pc_sel;
  logic                trap_take;
  logic                wdt_fire;
  commit_rec_t         rec_in [NCOMMIT];
  commit_rec_t         cmt_q  [NCOMMIT];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      hit[i] = in_valid[i] && (in_inst[i*32 +: 7] == TRAP_OPCODE);
    end
  end

  commit_mask_pcnt #(.N(NCOMMIT), .CW(CW), .IW(IW)) u_mask (
    .valid    (in_valid),
    .hit      (hit),
    .unmasked (unmasked),
    .count    (pcnt),
    .hi_idx   (hi_idx)
  );

  // On a trap cycle the trap channel is by construction the highest survivor,
  // so one mux serves both trap_pc and the last-committed PC.
  assign pc_sel = in_pc[int'(hi_idx)*XLEN +: XLEN];

  always_comb begin
    for (int i = 0; i < NCOMMIT; i++) begin
      rec_in[i]       = '0;
      rec_in[i].pc    = CM_XLEN'(in_pc[i*XLEN +: XLEN]);
      rec_in[i].inst  = in_inst[i*32 +: 32];
      rec_in[i].wen   = in_wen[i] && (in_wdest[i*5 +: 5] != 5'd0);
      rec_in[i].wdest = in_wdest[i*5 +: 5];
      rec_in[i].wdata = CM_XLEN'(in_wdata[i*XLEN +: XLEN]);
      rec_in[i].skip  = in_skip[i];
    end
  end

`ifdef COMMIT_WATCHDOG_EN
  logic [31:0]     idle_q;
  logic [XLEN-1:0] last_pc_q;

  assign wdt_fire = (state_q == ST_RUN) && (unmasked == '0) &&
                    (idle_q == 32'(WDT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q    <= '0;
      last_pc_q <= '0;
    end else begin
      if (state_d != ST_RUN || unmasked != '0) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 32'd1;
      end
      if (state_q == ST_RUN && unmasked != '0) begin
        last_pc_q <= pc_sel;
      end
    end
  end
`else
  assign wdt_fire = 1'b0;

  // Only used by the watchdog build.
  logic unused_wdt;
  assign unused_wdt = ^{WDT_CODE, 32'(WDT_CYCLES)};
`endif

  logic unused_a0;
  assign unused_a0 = ^in_a0;

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    trap_take = 1'b0;
    if (state_q == ST_RUN) begin
      if (hit != '0) begin
        state_d   = ST_TRAPPED;
        trap_take = 1'b1;
      end else if (wdt_fire) begin
        state_d = ST_TRAPPED;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmt_valid <= '0;
      for (int i = 0; i < NCOMMIT; i++) begin
        cmt_q[i] <= '0;
      end
      trap      <= 1'b0;
      trap_code <= '0;
      trap_pc   <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state_q == ST_RUN) begin
      cmt_valid <= unmasked;
      for (int i = 0; i < NCOMMIT; i++) begin
        cmt_q[i] <= rec_in[i];
      end
      cycle_cnt <= cycle_cnt + 64'd1;
      instr_cnt <= instr_cnt + 64'(pcnt);
      if (trap_take) begin
        trap      <= 1'b1;
        trap_code <= in_a0[7:0];
        trap_pc   <= pc_sel;
      end
`ifdef COMMIT_WATCHDOG_EN
      else if (wdt_fire) begin
        trap      <= 1'b1;
        trap_code <= WDT_CODE;
        trap_pc   <= last_pc_q;
      end
`endif
    end else begin
      cmt_valid <= '0;
    end
  end

  for (genvar g = 0; g < NCOMMIT; g++) begin : g_out
    assign cmt_pc[g*XLEN +: XLEN]   = cmt_q[g].pc[XLEN-1:0];
    assign cmt_inst[g*32 +: 32]     = cmt_q[g].inst;
    assign cmt_wen[g]               = cmt_q[g].wen;
    assign cmt_wdest[g*8 +: 8]      = {3'b000, cmt_q[g].wdest};
    assign cmt_wdata[g*XLEN +: XLEN] = cmt_q[g].wdata[XLEN-1:0];
    assign cmt_skip[g]              = cmt_q[g].skip;
  end

endmodule

// File: tb/tb_commit_tracker.sv
// Randomized plus directed bench for commit_tracker against a behavioural model.
// Latency: checks every output 1 cycle after each input set.
// Backpressure: none.
module tb_commit_tracker;

  localparam int NC  = 2;
  localparam int XL  = 64;
  localparam int WDT = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NC-1:0]     in_valid;
  logic [NC*XL-1:0]  in_pc;
  logic [NC*32-1:0]  in_inst;
  logic [NC-1:0]     in_wen;
  logic [NC*5-1:0]   in_wdest;
  logic [NC*XL-1:0]  in_wdata;
  logic [NC-1:0]     in_skip;
  logic [XL-1:0]     in_a0;
  logic [NC-1:0]     cmt_valid;
  logic [NC*XL-1:0]  cmt_pc;
  logic [NC*32-1:0]  cmt_inst;
  logic [NC-1:0]     cmt_wen;
  logic [NC*8-1:0]   cmt_wdest;
  logic [NC*XL-1:0]  cmt_wdata;
  logic [NC-1:0]     cmt_skip;
  logic              trap;
  logic [7:0]        trap_code;
  logic [XL-1:0]     trap_pc;
  logic [63:0]       cycle_cnt;
  logic [63:0]       instr_cnt;

  commit_tracker #(.NCOMMIT(NC), .XLEN(XL), .WDT_CYCLES(WDT), .WDT_CODE(8'hff)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen),
    .in_wdest(in_wdest), .in_wdata(in_wdata), .in_skip(in_skip), .in_a0(in_a0),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen),
    .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .cmt_skip(cmt_skip),
    .trap(trap), .trap_code(trap_code), .trap_pc(trap_pc),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic        m_trapped;
  logic [7:0]  m_code;
  logic [63:0] m_tpc, m_cyc, m_icnt, m_last;
  int          m_idle;
  logic        e_valid [NC];
  logic [63:0] e_pc [NC];
  logic [31:0] e_inst [NC];
  logic        e_wen [NC];
  logic [7:0]  e_wdest [NC];
  logic [63:0] e_wdata [NC];
  logic        e_skip [NC];

  task automatic model_update();
    int k;
    int n;
    if (reset) begin
      m_trapped = 0; m_code = 0; m_tpc = 0; m_cyc = 0; m_icnt = 0; m_last = 0; m_idle = 0;
      for (int i = 0; i < NC; i++) begin
        e_valid[i] = 0; e_pc[i] = 0; e_inst[i] = 0; e_wen[i] = 0;
        e_wdest[i] = 0; e_wdata[i] = 0; e_skip[i] = 0;
      end
    end else if (!m_trapped) begin
      k = -1;
      for (int i = 0; i < NC; i++)
        if (k < 0 && in_valid[i] && in_inst[i*32 +: 7] == 7'h6b) k = i;
      n = 0;
      for (int i = 0; i < NC; i++) begin
        e_valid[i] = in_valid[i] && (k < 0 || i <= k);
        e_pc[i]    = in_pc[i*XL +: XL];
        e_inst[i]  = in_inst[i*32 +: 32];
        e_wen[i]   = in_wen[i] && (in_wdest[i*5 +: 5] != 0);
        e_wdest[i] = {3'b0, in_wdest[i*5 +: 5]};
        e_wdata[i] = in_wdata[i*XL +: XL];
        e_skip[i]  = in_skip[i];
      end
      m_cyc = m_cyc + 1;
`ifdef COMMIT_WATCHDOG_EN
      for (int i = 0; i < NC; i++) if (e_valid[i]) n++;
      if (k >= 0) begin
        m_trapped = 1; m_code = in_a0[7:0]; m_tpc = in_pc[k*XL +: XL];
      end else if (n == 0 && m_idle == WDT - 1) begin
        m_trapped = 1; m_code = 8'hff; m_tpc = m_last;
      end
      if (m_trapped || n > 0) m_idle = 0; else m_idle++;
      for (int i = 0; i < NC; i++) if (e_valid[i]) m_last = e_pc[i];
`else
      for (int i = 0; i < NC; i++) if (e_valid[i]) n++;
      if (k >= 0) begin
        m_trapped = 1; m_code = in_a0[7:0]; m_tpc = in_pc[k*XL +: XL];
      end
`endif
      m_icnt = m_icnt + 64'(n);
    end else begin
      for (int i = 0; i < NC; i++) e_valid[i] = 0;
    end
  endtask

  task automatic compare_all();
    chk("trap", 64'(trap), 64'(m_trapped));
    chk("trap_code", 64'(trap_code), 64'(m_code));
    chk("trap_pc", trap_pc, m_tpc);
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_icnt);
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("valid%0d", i), 64'(cmt_valid[i]), 64'(e_valid[i]));
      chk($sformatf("pc%0d", i), cmt_pc[i*XL +: XL], e_pc[i]);
      chk($sformatf("inst%0d", i), 64'(cmt_inst[i*32 +: 32]), 64'(e_inst[i]));
      chk($sformatf("wen%0d", i), 64'(cmt_wen[i]), 64'(e_wen[i]));
      chk($sformatf("wdest%0d", i), 64'(cmt_wdest[i*8 +: 8]), 64'(e_wdest[i]));
      chk($sformatf("wdata%0d", i), cmt_wdata[i*XL +: XL], e_wdata[i]);
      chk($sformatf("skip%0d", i), 64'(cmt_skip[i]), 64'(e_skip[i]));
    end
  endtask

  // Apply current inputs for one edge, then check outputs 1 time unit later.
  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_pc = '0; in_inst = '0; in_wen = '0;
    in_wdest = '0; in_wdata = '0; in_skip = '0; in_a0 = '0;
  endtask

  task automatic set_ch(input int i, input logic v, input logic [63:0] pc, input logic [31:0] inst);
    in_valid[i] = v;
    in_pc[i*XL +: XL] = pc;
    in_inst[i*32 +: 32] = inst;
  endtask

  task automatic rand_inputs(input int trap_pct);
    logic [31:0] w;
    for (int i = 0; i < NC; i++) begin
      w = $urandom;
      if ($urandom_range(0, 99) < trap_pct) w[6:0] = 7'h6b;
      set_ch(i, $urandom_range(0, 3) != 0, {32'h0, $urandom} & ~64'h3, w);
      in_wen[i] = $urandom_range(0, 1) == 1;
      in_wdest[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      in_wdata[i*XL +: XL] = {$urandom, $urandom};
      in_skip[i] = $urandom_range(0, 1) == 1;
    end
    in_a0 = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_trapped = 0; m_idle = 0;
    do_reset();

    // Both channels retiring for three cycles
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      set_ch(0, 1'b1, 64'h8000_0000, 32'h0000_0013);
      set_ch(1, 1'b1, 64'h8000_0004, 32'h0000_0013);
      step();
      chk("dual_valid", 64'(cmt_valid), 64'h3);
    end
    chk("dual_icnt", instr_cnt, 64'd6);
    chk("dual_ccnt", cycle_cnt, 64'd3);

    // Write to x0 is suppressed but data still passes through
    idle_inputs();
    set_ch(0, 1'b1, 64'h8000_0008, 32'h0000_0013);
    in_wen[0] = 1'b1; in_wdest[4:0] = 5'd0; in_wdata[63:0] = 64'hdead;
    step();
    chk("x0_wen", 64'(cmt_wen[0]), 64'd0);
    chk("x0_wdata", cmt_wdata[63:0], 64'hdead);

    // Trap on ch0 masks ch1
    idle_inputs();
    set_ch(0, 1'b1, 64'h8000_0010, 32'h0000_006b);
    set_ch(1, 1'b1, 64'h8000_0014, 32'h0000_0013);
    step();
    chk("trap_valid", 64'(cmt_valid), 64'h1);
    chk("trap_flag", 64'(trap), 64'd1);
    chk("trap_pc0", trap_pc, 64'h8000_0010);
    chk("trap_icnt", instr_cnt, 64'd8);
    for (int c = 0; c < 3; c++) begin
      rand_inputs(50);
      step();
    end
    chk("frozen_ccnt", cycle_cnt, 64'd5);

    // Trap with a0 code, then reset clears everything
    do_reset();
    idle_inputs();
    set_ch(0, 1'b1, 64'h8000_0100, 32'h0000_006b);
    in_a0 = 64'h1234;
    step();
    chk("code_34", 64'(trap_code), 64'h34);
    idle_inputs();
    do_reset();
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_cnt", cycle_cnt | instr_cnt, 64'd0);
    set_ch(1, 1'b1, 64'h8000_0200, 32'h0000_0013);
    step();
    chk("recount", instr_cnt, 64'd1);

    // Instruction counter wraps to zero
    force dut.instr_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instr_cnt;
    m_icnt = 64'hFFFF_FFFF_FFFF_FFFF;
    idle_inputs();
    set_ch(0, 1'b1, 64'h8000_0300, 32'h0000_0013);
    step();
    chk("wrap_icnt", instr_cnt, 64'd0);
    chk("wrap_notrap", 64'(trap), 64'd0);

`ifdef COMMIT_WATCHDOG_EN
    do_reset();
    idle_inputs();
    set_ch(1, 1'b1, 64'h8000_1000, 32'h0000_0013);
    step();
    idle_inputs();
    for (int c = 1; c <= WDT; c++) begin
      step();
      if (c == WDT - 1) chk("wdt_early", 64'(trap), 64'd0);
    end
    chk("wdt_trap", 64'(trap), 64'd1);
    chk("wdt_code", 64'(trap_code), 64'hff);
    chk("wdt_pc", trap_pc, 64'h8000_1000);
`endif

    // Random traffic with occasional traps and resets
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rand_inputs(3);
        if ($urandom_range(0, 7) == 0) in_valid = '0;
        step();
        if (m_trapped && $urandom_range(0, 9) == 0) do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
